// File: rtl/disp_arbiter_pkg.sv
// Shared definitions for the display arbiter: FSM encoding, blank pattern,
// requester count and the round-robin helper functions.
package disp_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } arb_state_e;

    localparam logic [7:0] BLANK = 8'hFF;
    localparam int         NREQ  = 3;

    // One-hot winner of a search that starts at ptr and wraps modulo NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [1:0]      ptr);
        logic [NREQ-1:0] win;
        logic [1:0]      c;
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            c = 2'((int'(ptr) + i) % NREQ);
            if ((win == '0) && req[c]) begin
                win[c] = 1'b1;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Pointer that gives the winner lowest priority next time.
    function automatic logic [1:0] rr_after(input logic [NREQ-1:0] win);
        logic [1:0] nxt;
        case (win)
            3'b001:  nxt = 2'd1;
            3'b010:  nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Request/pattern bus between the display requesters and the arbiter,
// plus the arbitrated digit patterns heading to disp_mux.
interface disp_arbiter_if;
    import disp_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [31:0]     pat0;
    logic [31:0]     pat1;
    logic [31:0]     pat2;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [7:0]      led0;
    logic [7:0]      led1;
    logic [7:0]      led2;
    logic [7:0]      led3;

    modport master (output req, pat0, pat1, pat2,
                    input  grant, busy, led0, led1, led2, led3);
    modport slave  (input  req, pat0, pat1, pat2,
                    output grant, busy, led0, led1, led2, led3);
endinterface

// File: rtl/disp_arbiter_tick_gen.sv
// Free-running prescaler: tick is high for one clk cycle every TICK_DIV cycles.
// Reusable by the other display animations.
module tick_gen #(
    parameter int TICK_DIV = 1388889,
    parameter int TW       = 21
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    logic [TW-1:0] cnt_r;
    logic          wrap_s;

    assign wrap_s = (cnt_r == TW'(TICK_DIV - 1));
    assign tick   = wrap_s;

    // Prescaler counter, wraps to zero on the tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + TW'(1);
        end
    end
endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum hold in ticks and a
// blank cycle between owners. Optional macro DISP_ARB_PRIO0_EN makes requester 0 urgent.
module disp_arbiter
    import disp_arbiter_pkg::*;
#(
    parameter int TICK_DIV = 1388889,
    parameter int HOLD     = 36,
    parameter int TW       = 21
) (
    input  logic           clk,
    input  logic           reset,
    disp_arbiter_if.slave  bus
);
    localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    arb_state_e      state_r, state_nxt_s;
    logic [NREQ-1:0] grant_r, grant_nxt_s;
    logic            busy_r;
    logic [1:0]      rr_ptr_r, rr_ptr_nxt_s;
    logic [HW-1:0]   hold_r;
    logic [31:0]     led_r;
    logic            tick_s;
    logic            new_grant_s;
    logic [NREQ-1:0] rr_win_s;
    logic [NREQ-1:0] pick_s;
    logic [1:0]      pick_ptr_s;
    logic            urgent_s;
    logic            owner_req_s;
    logic            other_req_s;
    logic            expired_s;

    tick_gen #(.TICK_DIV(TICK_DIV), .TW(TW)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign rr_win_s    = rr_pick(bus.req, rr_ptr_r);
    assign owner_req_s = |(bus.req & grant_r);
    assign other_req_s = |(bus.req & ~grant_r);
    assign expired_s   = (hold_r == HW'(HOLD));

    // Winner selection; the urgent requester 0 bypasses and preserves the pointer.
    always_comb begin
        pick_s     = rr_win_s;
        pick_ptr_s = rr_after(rr_win_s);
        urgent_s   = 1'b0;
`ifdef DISP_ARB_PRIO0_EN
        urgent_s = bus.req[0] & ~grant_r[0];
        if (bus.req[0]) begin
            pick_s     = 3'b001;
            pick_ptr_s = rr_ptr_r;
        end else begin
            pick_s     = rr_win_s;
            pick_ptr_s = rr_after(rr_win_s);
        end
`endif
    end

    // Next-state and next-grant logic.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        rr_ptr_nxt_s = rr_ptr_r;
        new_grant_s  = 1'b0;
        case (state_r)
            IDLE, SWITCH: begin
                if (|bus.req) begin
                    state_nxt_s  = OWN;
                    grant_nxt_s  = pick_s;
                    rr_ptr_nxt_s = pick_ptr_s;
                    new_grant_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                end
            end
            OWN: begin
                if (!owner_req_s || (expired_s && other_req_s) || urgent_s) begin
                    state_nxt_s = SWITCH;
                    grant_nxt_s = '0;
                end else begin
                    state_nxt_s = OWN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // State, grant, pointer and hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            busy_r   <= 1'b0;
            rr_ptr_r <= 2'd0;
            hold_r   <= '0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            busy_r   <= |grant_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            if (new_grant_s) begin
                hold_r <= '0;
            end else if (tick_s && !expired_s) begin
                hold_r <= hold_r + HW'(1);
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Digit patterns follow the grant one cycle later, blank when unowned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r <= {4{BLANK}};
        end else begin
            case (grant_r)
                3'b001:  led_r <= bus.pat0;
                3'b010:  led_r <= bus.pat1;
                3'b100:  led_r <= bus.pat2;
                default: led_r <= {4{BLANK}};
            endcase
        end
    end

    assign bus.grant = grant_r;
    assign bus.busy  = busy_r;
    assign bus.led0  = led_r[7:0];
    assign bus.led1  = led_r[15:8];
    assign bus.led2  = led_r[23:16];
    assign bus.led3  = led_r[31:24];
endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed table, corner-case sequences
// and random traffic against an owner/hold reference model.
module tb_disp_arbiter;
    localparam int TICK_DIV = 4;
    localparam int HOLD     = 3;
    localparam int TW       = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    disp_arbiter_if bus();

    disp_arbiter #(.TICK_DIV(TICK_DIV), .HOLD(HOLD), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          m_owner;
    int          m_hold;
    int          m_rr;
    int          m_pre;
    logic [31:0] m_led;

    typedef struct {
        logic [2:0] req;
        logic [2:0] exp_grant;
        int         exp_src;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat_of(input int i);
        case (i)
            0:       return bus.pat0;
            1:       return bus.pat1;
            2:       return bus.pat2;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [2:0] oh(input int o);
        if (o < 0) return 3'b000;
        return 3'(1 << o);
    endfunction

    function automatic logic [31:0] leds();
        return {bus.led3, bus.led2, bus.led1, bus.led0};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_rr    = 0;
        m_pre   = 0;
        m_led   = 32'hFFFF_FFFF;
    endtask

    // One clock edge of the reference: who owns the display after this edge.
    task automatic model_edge();
        logic [2:0] r;
        bit tick, drop, others, expired, urgent, by_prio;
        int win, c;
        r       = bus.req;
        tick    = (m_pre == TICK_DIV - 1);
        m_pre   = (m_pre + 1) % TICK_DIV;
        m_led   = (m_owner < 0) ? 32'hFFFF_FFFF : pat_of(m_owner);
        urgent  = 1'b0;
        by_prio = 1'b0;
        if (m_owner >= 0) begin
            drop    = ((r >> m_owner) & 3'b001) == 3'b000;
            others  = (r & ~oh(m_owner)) != 3'b000;
            expired = (m_hold == HOLD);
`ifdef DISP_ARB_PRIO0_EN
            urgent = r[0] && (m_owner != 0);
`endif
            if (drop || (expired && others) || urgent) m_owner = -1;
            else if (tick && m_hold < HOLD) m_hold++;
        end else if (r != 3'b000) begin
            win = -1;
`ifdef DISP_ARB_PRIO0_EN
            if (r[0]) begin
                win = 0;
                by_prio = 1'b1;
            end
`endif
            for (int i = 0; i < 3; i++) begin
                c = (m_rr + i) % 3;
                if (win < 0 && ((r >> c) & 3'b001) != 3'b000) win = c;
            end
            if (!by_prio) m_rr = (win + 1) % 3;
            m_owner = win;
            m_hold  = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_grant"}, {29'b0, bus.grant}, {29'b0, oh(m_owner)});
        check({tag, "_busy"}, {31'b0, bus.busy}, {31'b0, (m_owner >= 0)});
        check({tag, "_leds"}, leds(), m_led);
        check({tag, "_onehot"}, {31'b0, ($countones(bus.grant) <= 1)}, 32'd1);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        bus.req = 3'b000;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_grant", {29'b0, bus.grant}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_leds", leds(), 32'hFFFF_FFFF);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl [15];
        logic [2:0] seq [$];
        int         runs[$];
        int         gaps[$];
        logic [2:0] exp_seq[4];
        logic [2:0] g;
        int         run, gap;
        bit         found;

        bus.req  = 3'b000;
        bus.pat0 = 32'hC0F9A4B0;
        bus.pat1 = 32'h99920F80;
        bus.pat2 = 32'h88838646;
        model_reset();
        do_reset();

        // Directed table: single requesters, drops and a two-way pick.
        tbl[0]  = '{3'b000, 3'b000, -1};
        tbl[1]  = '{3'b010, 3'b010, -1};
        tbl[2]  = '{3'b010, 3'b010,  1};
        tbl[3]  = '{3'b010, 3'b010,  1};
        tbl[4]  = '{3'b000, 3'b000,  1};
        tbl[5]  = '{3'b000, 3'b000, -1};
        tbl[6]  = '{3'b100, 3'b100, -1};
        tbl[7]  = '{3'b100, 3'b100,  2};
        tbl[8]  = '{3'b000, 3'b000,  2};
        tbl[9]  = '{3'b000, 3'b000, -1};
        tbl[10] = '{3'b011, 3'b001, -1};
        tbl[11] = '{3'b011, 3'b001,  0};
        tbl[12] = '{3'b010, 3'b000,  0};
        tbl[13] = '{3'b010, 3'b010, -1};
        tbl[14] = '{3'b010, 3'b010,  1};
        for (int i = 0; i < 15; i++) begin
            bus.req = tbl[i].req;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("tbl_grant", {29'b0, bus.grant}, {29'b0, tbl[i].exp_grant});
            check("tbl_busy", {31'b0, bus.busy}, {31'b0, (tbl[i].exp_grant != 3'b000)});
            check("tbl_leds", leds(), pat_of(tbl[i].exp_src));
        end

        // Asynchronous reset while owned, then idle after release.
        bus.req = 3'b001;
        for (int i = 0; i < 3; i++) cycle("pre_rst");
        reset = 1'b1;
        #1;
        check("async_rst_grant", {29'b0, bus.grant}, 32'd0);
        check("async_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("async_rst_leds", leds(), 32'hFFFF_FFFF);
        bus.req = 3'b000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cycle("post_rst");
        check("post_rst_idle", {29'b0, bus.grant}, 32'd0);

        // All three requesting: rotation, hold length and single blank gap.
        do_reset();
        bus.req = 3'b111;
        run = 0;
        gap = 0;
        for (int i = 0; i < 60; i++) begin
            cycle("rr");
            g = bus.grant;
            if (g != 3'b000) begin
                if (run == 0) begin
                    seq.push_back(g);
                    if (seq.size() > 1) gaps.push_back(gap);
                end
                run++;
                gap = 0;
            end else begin
                if (run > 0) runs.push_back(run);
                run = 0;
                gap++;
            end
        end
`ifdef DISP_ARB_PRIO0_EN
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        check("rr_owner_count", {31'b0, (seq.size() >= 4 && runs.size() >= 3)}, 32'd1);
        if (seq.size() >= 4 && runs.size() >= 3 && gaps.size() >= 3) begin
            for (int i = 0; i < 4; i++)
                check("rr_order", {29'b0, seq[i]}, {29'b0, exp_seq[i]});
            for (int i = 0; i < 3; i++) begin
                check("rr_hold_len", {31'b0, (runs[i] >= (HOLD - 1) * TICK_DIV + 2 &&
                                             runs[i] <= HOLD * TICK_DIV + 1)}, 32'd1);
                check("rr_gap", gaps[i], 32'd1);
            end
        end

        // Lone owner is never preempted; a competitor wins once expired.
        do_reset();
        bus.req = 3'b001;
        for (int i = 0; i < 100; i++) cycle("lone");
        check("lone_hold", {29'b0, bus.grant}, 32'd1);
        bus.req = 3'b101;
        found = 1'b0;
        for (int i = 0; i < TICK_DIV + 1 && !found; i++) begin
            cycle("preempt");
            if (bus.grant == 3'b000) found = 1'b1;
        end
        check("preempt_switch", {31'b0, found}, 32'd1);
        cycle("preempt_next");
`ifdef DISP_ARB_PRIO0_EN
        check("preempt_owner", {29'b0, bus.grant}, 32'd1);
`else
        check("preempt_owner", {29'b0, bus.grant}, 32'd4);
`endif

        // Owner drops exactly on the expiry cycle with requester 1 pending.
        do_reset();
        bus.req = 3'b011;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle("expdrop_wait");
            if (m_owner == 0 && m_hold == HOLD) found = 1'b1;
        end
        check("expdrop_reached", {31'b0, found}, 32'd1);
        bus.req = 3'b010;
        cycle("expdrop_sw");
        check("expdrop_blank", {29'b0, bus.grant}, 32'd0);
        cycle("expdrop_own");
        check("expdrop_grant", {29'b0, bus.grant}, 32'd2);

        // Requester 0 arriving while requester 2 has just been granted.
        do_reset();
        bus.req = 3'b100;
        cycle("urg_own");
        bus.req = 3'b101;
        cycle("urg_1");
`ifdef DISP_ARB_PRIO0_EN
        check("urg_switch", {29'b0, bus.grant}, 32'd0);
        cycle("urg_2");
        check("urg_grant0", {29'b0, bus.grant}, 32'd1);
`else
        check("urg_hold", {29'b0, bus.grant}, 32'd4);
        cycle("urg_2");
        check("urg_hold2", {29'b0, bus.grant}, 32'd4);
`endif
        for (int i = 0; i < 20; i++) cycle("urg_tail");

        // Random level requests, pattern changes and occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.req[$urandom_range(0, 2)] = ~bus.req[$urandom_range(0, 2)];
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bus.pat0 = $urandom;
                    1:       bus.pat1 = $urandom;
                    default: bus.pat2 = $urandom;
                endcase
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
